// File: rtl/cmd_parser.sv
// Receive-side command decoder: frames SYNC/ID/LEN/payload/CHK packets from the serial link.
// Optional reply path (ACK byte or NAK) enabled by defining CMD_PARSER_ACK_EN.
module cmd_parser #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned MAX_LEN = 4,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 new_rx_data,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_id,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_arg,
`ifdef CMD_PARSER_ACK_EN
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
`endif
  output logic [7:0]           err_count
);

  localparam int unsigned    TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TmoLast = TW'(TIMEOUT - 1);
  localparam logic [7:0]     MaxLen  = 8'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StGetId, StGetLen, StGetPay, StGetChk} state_e;

  state_e                 state_q;
  logic [7:0]             id_q;
  logic [3:0]             len_q;
  logic [8*MAX_LEN-1:0]   arg_q;
  logic [7:0]             sum_q;
  logic [3:0]             idx_q;
  logic [TW-1:0]          tmo_q;
  logic                   good_q;

  logic tmo_hit, len_bad, chk_bad, chk_good, err_inc;

  always_comb begin
    tmo_hit  = (state_q != StIdle) && !new_rx_data && (tmo_q == TmoLast);
    len_bad  = new_rx_data && (state_q == StGetLen) && (rx_data > MaxLen);
    chk_bad  = new_rx_data && (state_q == StGetChk) && (rx_data != sum_q);
    chk_good = new_rx_data && (state_q == StGetChk) && (rx_data == sum_q);
    err_inc  = tmo_hit || len_bad || chk_bad;
  end

  // Framing FSM; working registers only touched from GET_ID onward, so they stay
  // stable for the cycle after CHK when the outputs copy them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= '0;
      len_q   <= '0;
      arg_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      good_q  <= 1'b0;
    end else begin
      good_q <= chk_good;
      if (state_q == StIdle || new_rx_data || tmo_hit) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (tmo_hit) begin
        state_q <= StIdle;
      end else if (new_rx_data) begin
        unique case (state_q)
          StIdle: begin
            if (rx_data == SYNC) state_q <= StGetId;
          end
          StGetId: begin
            id_q    <= rx_data;
            sum_q   <= rx_data;
            state_q <= StGetLen;
          end
          StGetLen: begin
            sum_q <= sum_q + rx_data;
            idx_q <= '0;
            arg_q <= '0;
            len_q <= rx_data[3:0];
            if (rx_data > MaxLen) begin
              state_q <= StIdle;
            end else if (rx_data == 8'd0) begin
              state_q <= StGetChk;
            end else begin
              state_q <= StGetPay;
            end
          end
          StGetPay: begin
            arg_q[idx_q*8 +: 8] <= rx_data;
            sum_q               <= sum_q + rx_data;
            idx_q               <= idx_q + 4'd1;
            if (idx_q == len_q - 4'd1) state_q <= StGetChk;
          end
          StGetChk: state_q <= StIdle;
          default:  state_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      cmd_len   <= '0;
      cmd_arg   <= '0;
    end else begin
      cmd_valid <= good_q;
      if (good_q) begin
        cmd_id  <= id_q;
        cmd_len <= len_q;
        cmd_arg <= arg_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_inc && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

`ifdef CMD_PARSER_ACK_EN
  logic       pend_q;
  logic [7:0] pend_data_q;

  // A reply loaded on the same cycle the old one leaves simply takes the slot next.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      new_tx_data <= 1'b0;
      tx_data     <= '0;
    end else begin
      new_tx_data <= 1'b0;
      if (pend_q && !tx_busy) begin
        new_tx_data <= 1'b1;
        tx_data     <= pend_data_q;
        pend_q      <= 1'b0;
      end
      if (good_q) begin
        pend_q      <= 1'b1;
        pend_data_q <= id_q;
      end else if (chk_bad) begin
        pend_q      <= 1'b1;
        pend_data_q <= 8'h15;
      end
    end
  end
`endif

endmodule
